voice_allocator: RTL
====================

# voice_allocator

Polyphonic voice allocator that sits upstream of the per-voice `rc_filter_fsm` envelope generators. Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a free voice. Drives that voice's `en` level and 32-bit velocity word (attack level in the upper 16 bits, decay level in the lower 16). Reclaims a voice when its envelope generator pulses `available`.

## Interface
- `NUM_VOICES`, 8: number of envelope/oscillator voices managed.
- `NOTE_BITS`, 7: MIDI note number width.
- `AGE_BITS`, 4: per-voice age counter width, saturating.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `ev_valid` in 1: event present.
- `ev_ready` out 1: allocator can accept an event.
- `ev_on` in 1: 1 = note-on, 0 = note-off.
- `ev_note` in NOTE_BITS: note number.
- `ev_velocity` in 32: velocity word forwarded to the voice.
- `voice_avail` in NUM_VOICES: per-voice one-cycle `available` pulses from the envelope generators.
- `voice_en` out NUM_VOICES: per-voice gate, high while the key is held.
- `voice_note` out NUM_VOICES*NOTE_BITS: note assigned to each voice, packed with voice 0 in the LSBs.
- `voice_velocity` out NUM_VOICES*32: velocity assigned to each voice, packed the same way.
- `dropped` out 1: one-cycle pulse when an event is discarded.

## Operation
- Per-voice state: V_FREE, V_HELD (`en`=1), V_RELEASE (`en`=0, waiting for the `available` pulse).
- Controller FSM:
  - S_IDLE: `ev_ready`=1. On `ev_valid`, latch on/note/velocity and go to S_COMMIT.
  - S_COMMIT: `ev_ready`=0. Perform the decision below, then return to S_IDLE.
- Note-on decision, in priority order:
  1. A V_HELD voice already has the same note: retrigger it. Update velocity; `en` stays high.
  2. Otherwise, take the lowest-index V_FREE voice. Load note and velocity, set V_HELD, `en`=1.
  3. Otherwise, no voice is free: steal or drop, per Configuration.
- Note-off: the lowest-index V_HELD voice with a matching note goes to V_RELEASE and `en`=0. With no match, pulse `dropped`.
- Allocation or steal clears the target voice's age. Every other non-free voice's age increments by 1, saturating at 2^AGE_BITS-1.
- `voice_avail[i]` handling:
  - In V_RELEASE or V_HELD: voice goes to V_FREE and `en`=0.
  - In V_FREE: ignored.
- A note and velocity stay on the outputs after a voice frees; only `en` changes.

## Timing
- Reset: state S_IDLE, all voices V_FREE, ages 0.
- Reset output values: `ev_ready`=1, `voice_en`=0, `voice_note`=0, `voice_velocity`=0, `dropped`=0.
- Latency: handshake in cycle N, decision in cycle N+1, updated `voice_en`/`voice_note`/`voice_velocity`/`dropped` visible from cycle N+2.
- Throughput: one event per 2 cycles.
- The handshake completes only when `ev_valid` and `ev_ready` are both high. The source holds all `ev_*` fields stable while `ev_valid` is high without `ev_ready`.
- Simultaneous `voice_avail[i]` and a commit targeting voice i:
  - The commit wins: voice ends V_HELD with `en`=1.
  - The free search in that cycle uses the registered state, so voice i counts as free only if it was already V_FREE.
- Reset mid-operation: asynchronous. All gates drop immediately and the latched event is lost.

## Configuration
- `VOICE_STEAL_EN` defined: a note-on with no free voice steals the oldest voice.
  - Oldest V_RELEASE voice is chosen first, then the oldest V_HELD voice.
  - Ties go to the lowest index.
  - The stolen voice loads the new note and velocity, with `en`=1.
  - `dropped` stays low.
- Undefined: the note-on is discarded and `dropped` pulses. Age counters and their logic are removed.

## Structure
- Shared package `synth_voice_pkg`:
  - voice-state encodings V_FREE/V_HELD/V_RELEASE;
  - FSM encodings S_IDLE/S_COMMIT;
  - velocity width constant 32.
- One sub-module, `voice_prio_enc`: parameterised lowest-index-set priority encoder returning index plus found flag. It is instantiated for the free search, the note-match search and the steal search.

## Test plan
- Reset, then note-on 60 with velocity 0xF000_8000 -> from cycle 2, `voice_en`=0x01, `voice_note[0]`=60, `voice_velocity[0]`=0xF000_8000.
- Note-ons 60, 62, 64, then note-off 62 -> `voice_en` goes 0x01, 0x03, 0x07, 0x05; then pulse `voice_avail[1]` -> voice 1 is reused by the next note-on.
- Note-on 60 twice with velocities A then B -> only voice 0 is used, `voice_velocity[0]`=B, `voice_en`=0x01.
- Nine note-ons with NUM_VOICES=8, macro undefined -> ninth raises `dropped` for one cycle, `voice_en`=0xFF, all notes unchanged.
- Same nine note-ons with `VOICE_STEAL_EN` -> voice 0 (oldest) gets note 9, `dropped`=0. Repeat with voice 3 in release -> voice 3 is stolen.
- Note-off 70 with no match -> `dropped` pulse, no gate change. Assert `rst` mid-S_COMMIT -> `voice_en`=0 and `ev_ready`=1 with no clock edge.

Source files
------------

// File: rtl/synth_voice_pkg.sv
// Shared encodings for the voice allocator and its helpers.
package synth_voice_pkg;
  localparam int VEL_W = 32;

  typedef enum logic [1:0] {
    V_FREE    = 2'd0,
    V_HELD    = 2'd1,
    V_RELEASE = 2'd2
  } vstate_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } fsm_e;

  // What the commit cycle does to its target voice.
  typedef enum logic [1:0] {
    A_NONE   = 2'd0,
    A_RETRIG = 2'd1,
    A_LOAD   = 2'd2,
    A_REL    = 2'd3
  } act_e;
endpackage

// File: rtl/voice_prio_enc.sv
// Lowest-index-set priority encoder: index of the first set request plus a found flag.
module voice_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto free voices and drives gates.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping when none are free.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS  = 7,
  parameter int AGE_BITS   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [VEL_W-1:0]                ev_velocity,
  input  logic [NUM_VOICES-1:0]           voice_avail,
  output logic [NUM_VOICES-1:0]           voice_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]     voice_velocity,
  output logic                            dropped
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  fsm_e                                 state;
  logic                                 lat_on;
  logic [NOTE_BITS-1:0]                 lat_note;
  logic [VEL_W-1:0]                     lat_vel;
  vstate_e                              vst [NUM_VOICES];
  logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note_q;
  logic [NUM_VOICES-1:0][VEL_W-1:0]     vel_q;

  logic [NUM_VOICES-1:0] free_m, held_m, match_m;
  logic [IW-1:0]         free_idx, match_idx, tgt;
  logic                  free_found, match_found, drop_d;
  act_e                  act;

  always_comb begin
    free_m  = '0;
    held_m  = '0;
    match_m = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      free_m[i]  = (vst[i] == V_FREE);
      held_m[i]  = (vst[i] == V_HELD);
      match_m[i] = (vst[i] == V_HELD) && (note_q[i] == lat_note);
    end
  end

  voice_prio_enc #(.N(NUM_VOICES), .IW(IW)) u_free (
    .req(free_m), .idx(free_idx), .found(free_found)
  );
  voice_prio_enc #(.N(NUM_VOICES), .IW(IW)) u_match (
    .req(match_m), .idx(match_idx), .found(match_found)
  );

`ifdef VOICE_STEAL_EN
  logic [NUM_VOICES-1:0][AGE_BITS-1:0] age_q;
  logic [NUM_VOICES-1:0]               rel_m, cand_m, steal_m;
  logic [AGE_BITS-1:0]                 max_age;
  logic [IW-1:0]                       steal_idx;
  logic                                steal_found;

  // Released voices are preferred victims; among candidates the oldest wins, ties to lowest index.
  always_comb begin
    rel_m   = '0;
    steal_m = '0;
    max_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) rel_m[i] = (vst[i] == V_RELEASE);
    cand_m = (|rel_m) ? rel_m : held_m;
    for (int i = 0; i < NUM_VOICES; i++)
      if (cand_m[i] && age_q[i] > max_age) max_age = age_q[i];
    for (int i = 0; i < NUM_VOICES; i++)
      steal_m[i] = cand_m[i] && (age_q[i] == max_age);
  end

  voice_prio_enc #(.N(NUM_VOICES), .IW(IW)) u_steal (
    .req(steal_m), .idx(steal_idx), .found(steal_found)
  );
`endif

  always_comb begin
    act    = A_NONE;
    tgt    = match_idx;
    drop_d = 1'b0;
    if (state == S_COMMIT) begin
      if (match_found) begin
        act = lat_on ? A_RETRIG : A_REL;
      end else if (!lat_on) begin
        drop_d = 1'b1;
      end else if (free_found) begin
        act = A_LOAD;
        tgt = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        if (steal_found) begin
          act = A_LOAD;
          tgt = steal_idx;
        end else begin
          drop_d = 1'b1;
        end
`else
        drop_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ev_ready <= 1'b1;
      dropped  <= 1'b0;
      lat_on   <= 1'b0;
      lat_note <= '0;
      lat_vel  <= '0;
    end else begin
      dropped <= drop_d;
      case (state)
        S_IDLE: begin
          if (ev_valid) begin
            lat_on   <= ev_on;
            lat_note <= ev_note;
            lat_vel  <= ev_velocity;
            state    <= S_COMMIT;
            ev_ready <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          ev_ready <= 1'b1;
        end
      endcase
    end
  end

  // A commit on a voice overrides a same-cycle available pulse for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        vst[i]    <= V_FREE;
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (tgt == IW'(i) && (act == A_LOAD || act == A_RETRIG)) begin
          vst[i]   <= V_HELD;
          vel_q[i] <= lat_vel;
          if (act == A_LOAD) note_q[i] <= lat_note;
        end else if (tgt == IW'(i) && act == A_REL) begin
          vst[i] <= V_RELEASE;
        end else if (voice_avail[i] && vst[i] != V_FREE) begin
          vst[i] <= V_FREE;
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else if (act == A_LOAD) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (tgt == IW'(i)) age_q[i] <= '0;
        else if (vst[i] != V_FREE && age_q[i] != {AGE_BITS{1'b1}}) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    voice_en = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_en[i] = (vst[i] == V_HELD);
  end

  assign voice_note     = note_q;
  assign voice_velocity = vel_q;
endmodule
